// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: state encoding, unlock addresses and command bytes shared by the flash program sequencer
package flash_seq_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNLOCK1   = 3'd1,
    UNLOCK2   = 3'd2,
    PROGRAM   = 3'd3,
    ERASE_ARM = 3'd4,
    ERASE_U1  = 3'd5,
    ERASE_U2  = 3'd6,
    BUSY      = 3'd7
  } state_e;
  localparam logic [11:0] U1 = 12'h555;
  localparam logic [11:0] U2 = 12'h2AA;
  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_10 = 8'h10;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_F0 = 8'hF0;
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/flash_seq_timer.sv
// flash_seq_timer: loadable down-counter that parks at zero and flags it
module flash_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  // load has priority over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && !zero_o) cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/flash_prg_sequencer.sv
// flash_prg_sequencer: JEDEC-style unlock/program/erase command tracker; FLASH_SEQ_TIMEOUT_EN abandons stale partial unlocks
module flash_prg_sequencer
  import flash_seq_pkg::*;
#(
  parameter int PROG_CYCLES    = 20,
  parameter int ERASE_CYCLES   = 65535,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        cpu_wr_valid,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        prg_write_enabled,
  output logic        flash_we_gate,
  output logic        busy,
  output logic        error,
  output logic [2:0]  seq_state
);
  localparam int CW = cnt_w(ERASE_CYCLES, TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic error_q, error_d;
  logic ld, dec, zero;
  logic [CW-1:0] ld_val;
  logic wr_en, wr, u1, u2;
  logic [7:0] d;
  logic unused_addr;
  assign unused_addr = ^cpu_addr_in[14:12];
  assign d = cpu_data_in;
  assign u1 = cpu_addr_in[11:0] == U1;
  assign u2 = cpu_addr_in[11:0] == U2;
  assign busy = state_q == BUSY;
  assign wr_en = cpu_wr_valid & prg_write_enabled;
  assign wr = wr_en & ~busy;
  assign flash_we_gate = wr;
  assign error = error_q;
  assign seq_state = state_q;
  flash_seq_timer #(.W(CW)) u_timer (
    .clk(m2), .rst(reset), .load_i(ld), .val_i(ld_val), .dec_i(dec), .zero_o(zero)
  );
  // state and sticky error register
  always_ff @(posedge m2) begin
    if (reset) begin
      state_q <= IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end
  // command decode; only accepted writes advance, BUSY ignores writes and counts down
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    ld = 1'b0;
    ld_val = '0;
    dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr) state_d = (u1 && d == CMD_AA) ? UNLOCK1 : IDLE;
        if (wr && d == CMD_F0) error_d = 1'b0;
      end
      UNLOCK1: if (wr) state_d = (u2 && d == CMD_55) ? UNLOCK2 : IDLE;
      UNLOCK2: if (wr) state_d = !u1 ? IDLE : d == CMD_A0 ? PROGRAM : d == CMD_80 ? ERASE_ARM : IDLE;
      PROGRAM: if (wr) begin
        state_d = BUSY;
        ld = 1'b1;
        ld_val = CW'(PROG_CYCLES - 1);
      end
      ERASE_ARM: if (wr) state_d = (u1 && d == CMD_AA) ? ERASE_U1 : IDLE;
      ERASE_U1: if (wr) state_d = (u2 && d == CMD_55) ? ERASE_U2 : IDLE;
      ERASE_U2: if (wr) begin
        state_d = ((u1 && d == CMD_10) || d == CMD_30) ? BUSY : IDLE;
        ld = state_d == BUSY;
        ld_val = CW'(ERASE_CYCLES - 1);
      end
      BUSY: begin
        dec = 1'b1;
        if (zero) state_d = IDLE;
        if (wr_en) error_d = 1'b1;
      end
    endcase
`ifdef FLASH_SEQ_TIMEOUT_EN
    if (!wr && state_q inside {UNLOCK1, UNLOCK2, ERASE_ARM, ERASE_U1, ERASE_U2}) begin
      dec = 1'b1;
      if (zero) state_d = IDLE;
    end
    if (wr && state_d inside {UNLOCK1, UNLOCK2, ERASE_ARM, ERASE_U1, ERASE_U2}) begin
      ld = 1'b1;
      ld_val = CW'(TIMEOUT_CYCLES - 1);
    end
`else
`endif
  end
endmodule

// File: tb/tb_flash_prg_sequencer.sv
// tb_flash_prg_sequencer: scoreboard bench for the flash program/erase sequencer
module tb_flash_prg_sequencer;
  logic m2 = 1'b0, reset = 1'b1, cpu_wr_valid = 1'b0, prg_write_enabled = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0] cpu_data_in = '0;
  logic flash_we_gate, busy, error;
  logic [2:0] seq_state;
  int passed = 0, total = 0;
  int exp_q[$];
  always #5 m2 = ~m2;
  flash_prg_sequencer #(.PROG_CYCLES(20), .ERASE_CYCLES(100), .TIMEOUT_CYCLES(255)) dut (
    .m2(m2), .reset(reset), .cpu_wr_valid(cpu_wr_valid), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .prg_write_enabled(prg_write_enabled),
    .flash_we_gate(flash_we_gate), .busy(busy), .error(error), .seq_state(seq_state)
  );
  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic push(input int v);
    exp_q.push_back(v);
  endtask
  task automatic score(input string tag, input int act);
    if (exp_q.size() == 0) check({tag, " (no expectation)"}, act, -1);
    else check(tag, act, exp_q.pop_front());
  endtask
  task automatic wr(input logic [14:0] a, input logic [7:0] dv, input int eg);
    @(negedge m2);
    cpu_wr_valid = 1'b1;
    cpu_addr_in = a;
    cpu_data_in = dv;
    push(eg);
    #1 score("gate", int'(flash_we_gate));
    @(negedge m2);
    cpu_wr_valid = 1'b0;
  endtask
  task automatic st(input string tag, input int e);
    push(e);
    score(tag, int'(seq_state));
  endtask
  task automatic flag(input string tag, input logic v, input int e);
    push(e);
    score(tag, int'(v));
  endtask
  task automatic busy_len(input string tag, input int e);
    int n;
    n = 0;
    push(e);
    while (busy && n < 2000) begin
      n++;
      @(negedge m2);
    end
    score(tag, n);
  endtask
  task automatic erase_unlock();
    wr(15'h0555, 8'hAA, 1);
    wr(15'h02AA, 8'h55, 1);
    wr(15'h0555, 8'h80, 1);
    wr(15'h0555, 8'hAA, 1);
    wr(15'h02AA, 8'h55, 1);
  endtask
  initial begin
    repeat (3) @(negedge m2);
    st("reset_state", 0);
    flag("reset_busy", busy, 0);
    flag("reset_error", error, 0);
    flag("reset_gate", flash_we_gate, 0);
    reset = 1'b0;
    wr(15'h0555, 8'hAA, 1); st("prg_u1", 1);
    wr(15'h02AA, 8'h55, 1); st("prg_u2", 2);
    wr(15'h0555, 8'hA0, 1); st("prg_arm", 3);
    wr(15'h1234, 8'h3C, 1); st("prg_busy_state", 7);
    busy_len("prg_busy_len", 20);
    st("prg_done", 0);
    erase_unlock(); st("erase_u2", 6);
    wr(15'h0000, 8'h30, 1);
    busy_len("sector_busy_len", 100);
    st("sector_done", 0);
    erase_unlock();
    wr(15'h0000, 8'h10, 1); st("chip_bad_addr", 0);
    erase_unlock();
    wr(15'h7555, 8'h10, 1);
    busy_len("chip_busy_len", 100);
    wr(15'h0555, 8'hAA, 1);
    wr(15'h02AA, 8'h55, 1);
    wr(15'h0555, 8'hF0, 1); st("f0_in_unlock2", 0);
    wr(15'h0555, 8'hAA, 1);
    wr(15'h02AA, 8'h55, 1);
    wr(15'h0555, 8'hA0, 1);
    wr(15'h0100, 8'h3C, 1);
    wr(15'h0000, 8'hFF, 0);
    flag("busy_wr_error", error, 1);
    busy_len("busy_len_with_wr", 18);
    flag("error_sticky", error, 1);
    wr(15'h0000, 8'hF0, 1);
    flag("f0_clears_error", error, 0);
    wr(15'h0555, 8'hAA, 1); st("bad_u1", 1);
    wr(15'h02AA, 8'h54, 1); st("bad_u2", 0);
    wr(15'h0555, 8'hAA, 1);
`ifdef FLASH_SEQ_TIMEOUT_EN
    repeat (254) @(negedge m2);
    st("timeout_before", 1);
    @(negedge m2);
    st("timeout_after", 0);
`else
    repeat (300) @(negedge m2);
    st("no_timeout_hold", 1);
    wr(15'h0000, 8'h00, 1);
    st("no_timeout_exit", 0);
`endif
    wr(15'h0555, 8'hAA, 1);
    wr(15'h02AA, 8'h55, 1);
    wr(15'h0555, 8'hA0, 1);
    wr(15'h0100, 8'h3C, 1);
    wr(15'h0000, 8'hFF, 0);
    repeat (12) @(negedge m2);
    reset = 1'b1;
    cpu_wr_valid = 1'b1;
    cpu_addr_in = 15'h0555;
    cpu_data_in = 8'hAA;
    #1 flag("rst_gate_while_busy", flash_we_gate, 0);
    @(negedge m2);
    st("rst_state", 0);
    flag("rst_busy", busy, 0);
    flag("rst_error", error, 0);
    flag("rst_gate_follows_valid", flash_we_gate, 1);
    @(negedge m2);
    st("rst_no_advance", 0);
    cpu_wr_valid = 1'b0;
    reset = 1'b0;
    prg_write_enabled = 1'b0;
    wr(15'h0555, 8'hAA, 0); st("dis_u1", 0);
    wr(15'h02AA, 8'h55, 0);
    wr(15'h0555, 8'hA0, 0);
    wr(15'h1234, 8'h3C, 0);
    st("dis_final", 0);
    flag("dis_busy", busy, 0);
    flag("dis_error", error, 0);
    prg_write_enabled = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flash_prg_sequencer.md
FLASH_PRG_SEQUENCER -- requirements
Module: flash_prg_sequencer

Interface
REQ-001 SHALL have parameter PROG_CYCLES, default 20, meaning m2 cycles the flash is busy after a program write.
REQ-002 SHALL have parameter ERASE_CYCLES, default 65535, meaning m2 cycles the flash is busy after a sector or chip erase command.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning idle m2 cycles before a partial unlock is abandoned.
REQ-004 SHALL have port m2, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port cpu_wr_valid, input, 1 bit: one-cycle pulse per CPU write to the ROM area ($8000-$FFFF).
REQ-007 SHALL have port cpu_addr_in, input, 15 bits: CPU address qualified by cpu_wr_valid.
REQ-008 SHALL have port cpu_data_in, input, 8 bits: CPU write data qualified by cpu_wr_valid.
REQ-009 SHALL have port prg_write_enabled, input, 1 bit: mapper permission for flash writes.
REQ-010 SHALL have port flash_we_gate, output, 1 bit: permits the current write to reach flash_we.
REQ-011 SHALL have port busy, output, 1 bit: flash program/erase is in progress.
REQ-012 SHALL have port error, output, 1 bit: sticky flag, set on a write attempted while busy.
REQ-013 SHALL have port seq_state, output, 3 bits: current state encoding.

Function
REQ-014 SHALL decode addresses on cpu_addr_in[11:0] only: U1 = 12'h555, U2 = 12'h2AA.
REQ-015 SHALL implement states IDLE, UNLOCK1, UNLOCK2, PROGRAM, ERASE_ARM, ERASE_U1, ERASE_U2 and BUSY.
REQ-016 SHALL, in IDLE, on AA@U1 go to UNLOCK1, and on any other write stay in IDLE.
REQ-017 SHALL, in UNLOCK1, on 55@U2 go to UNLOCK2, and otherwise return to IDLE.
REQ-018 SHALL, in UNLOCK2, on A0@U1 go to PROGRAM, on 80@U1 go to ERASE_ARM, and on anything else (including F0) return to IDLE.
REQ-019 SHALL, in PROGRAM, on the next write at any address go to BUSY and load the counter with PROG_CYCLES-1.
REQ-020 SHALL step ERASE_ARM -> ERASE_U1 on AA@U1 and ERASE_U1 -> ERASE_U2 on 55@U2; a mismatch in either returns to IDLE.
REQ-021 SHALL, in ERASE_U2, on 10@U1 (chip erase) or 30@any (sector erase) go to BUSY and load ERASE_CYCLES-1, and otherwise return to IDLE.
REQ-022 SHALL, in BUSY, decrement the counter each cycle and go to IDLE in the cycle after it reads 0.
REQ-023 SHALL, in BUSY, ignore every write, hold flash_we_gate low and set error.
REQ-024 SHALL drive flash_we_gate combinationally, zero latency: cpu_wr_valid & prg_write_enabled & ~busy.
REQ-025 SHALL give writes with prg_write_enabled=0 no effect: no state change, no error.
REQ-026 SHALL treat a write arriving in the same cycle the counter reaches 0 as a BUSY write (REQ-023).
REQ-027 SHALL drive busy high exactly when the state is BUSY.
REQ-028 SHALL clear error on an F0 write accepted in IDLE.
REQ-029 SHALL use a counter width of clog2 of the maximum of ERASE_CYCLES and TIMEOUT_CYCLES; a loaded value of 0 gives one BUSY cycle.

Reset
REQ-030 SHALL, on reset, set state IDLE, counter 0, busy 0, error 0 and seq_state 3'd0, overriding any in-flight operation including BUSY.
REQ-031 SHALL keep flash_we_gate gated by cpu_wr_valid during reset; the state does not advance.

Configuration
REQ-032 SHALL, with FLASH_SEQ_TIMEOUT_EN defined, return any state other than IDLE, PROGRAM or BUSY to IDLE after TIMEOUT_CYCLES consecutive cycles without a write.
REQ-033 SHALL, without FLASH_SEQ_TIMEOUT_EN, hold partial-unlock states indefinitely.

Structure
REQ-034 SHALL place the state encoding (IDLE=0 ... BUSY=7), U1/U2 addresses and command bytes (AA, 55, A0, 80, 10, 30, F0) in the shared package flash_seq_pkg.
REQ-035 SHALL implement the counter as sub-module flash_seq_timer (loadable down-counter with zero flag), used for both BUSY duration and timeout.

Verification
REQ-036 SHALL verify program: AA@555, 55@2AA, A0@555, 3C@1234 -> flash_we_gate high on all four writes; busy high for 20 cycles, then IDLE.
REQ-037 SHALL verify sector erase: AA, 55, 80, AA, 55, 30@0000 -> busy high for ERASE_CYCLES (set to 100 in the bench), then IDLE.
REQ-038 SHALL verify a write during BUSY -> flash_we_gate=0 and error=1; a later F0 in IDLE -> error=0.
REQ-039 SHALL verify a bad sequence AA@555, 54@2AA -> state IDLE; with FLASH_SEQ_TIMEOUT_EN, AA@555 then 255 idle cycles -> IDLE.
REQ-040 SHALL verify reset asserted at BUSY count 5 -> next cycle IDLE, busy=0, error=0; prg_write_enabled=0 with a full sequence -> state stays IDLE.
